// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I instruction-fetch front end.
// Owns the program counter and issues word fetches to instruction memory.
// Returned words go into a small in-order buffer that decode drains through a
// valid/ready handshake. A redirect from execute flushes all buffered and
// in-flight fetches.
// Optional performance counters are enabled with the macro RV_FETCH_PERF_EN.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic        o_if_fault,
    input  logic        i_id_ready,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stall
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;

    // Tag queue: PC of each request still waiting for its response.
    logic [31:0]   tag_pc_q     [FIFO_DEPTH];
    // Instruction buffer presented to decode.
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic          fifo_fault_q [FIFO_DEPTH];

    logic          req_s;
    logic          grant_s;
    logic          pop_s;
    logic          push_s;
    logic [PW-1:0] push_idx_s;
    logic [31:0]   push_instr_s;
    logic [31:0]   push_pc_s;
    logic          push_fault_s;
    logic [CW:0]   credit_sum_s;

    // Credit check: in-flight requests plus buffered entries must leave room.
    always_comb begin
        credit_sum_s = {1'b0, outstanding_q} + {1'b0, count_q};
        req_s        = i_rst && (state_q == ST_RUN) && !i_redirect_valid &&
                       (credit_sum_s < {1'b0, DEPTH_C});
        grant_s      = req_s && i_imem_gnt;
    end

    // Next-state logic: redirect flush, request issue, response routing, pops.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        push_s        = 1'b0;
        push_idx_s    = wr_ptr_q;
        push_instr_s  = 32'h0000_0000;
        push_pc_s     = 32'h0000_0000;
        push_fault_s  = 1'b0;
        pop_s         = 1'b0;

        // Every response retires its tag, whether it is kept or dropped.
        tag_wr_d = grant_s       ? (tag_wr_q + PW'(1)) : tag_wr_q;
        tag_rd_d = i_imem_rvalid ? (tag_rd_q + PW'(1)) : tag_rd_q;

        if (i_redirect_valid) begin
            // Flush wins over any pop; everything still in flight is stale,
            // including a response arriving in this very cycle.
            pc_d          = i_redirect_pc;
            state_d       = ST_RUN;
            outstanding_d = outstanding_q - CW'(i_imem_rvalid);
            drop_d        = outstanding_q - CW'(i_imem_rvalid);
            rd_ptr_d      = {PW{1'b0}};
            wr_ptr_d      = {PW{1'b0}};
            count_d       = {CW{1'b0}};
            if (i_redirect_pc[1:0] != 2'b00) begin
                push_s       = 1'b1;
                push_idx_s   = {PW{1'b0}};
                push_instr_s = NOP_INSTR;
                push_pc_s    = i_redirect_pc;
                push_fault_s = 1'b1;
                wr_ptr_d     = PW'(1);
                count_d      = CW'(1);
                state_d      = ST_HALT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            if (grant_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            outstanding_d = outstanding_q + CW'(grant_s) - CW'(i_imem_rvalid);

            if (i_imem_rvalid) begin
                if (drop_q != {CW{1'b0}}) begin
                    drop_d = drop_q - CW'(1);
                end else if (state_q == ST_RUN) begin
                    push_s       = 1'b1;
                    push_instr_s = i_imem_err ? NOP_INSTR : i_imem_rdata;
                    push_pc_s    = tag_pc_q[tag_rd_q];
                    push_fault_s = i_imem_err;
                    if (i_imem_err) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    // Halted: late responses are drained and discarded.
                    drop_d = drop_q;
                end
            end else begin
                drop_d = drop_q;
            end

            pop_s    = (count_q != {CW{1'b0}}) && i_id_ready;
            wr_ptr_d = wr_ptr_q + PW'(push_s);
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State, pointer, tag-queue and buffer registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            drop_q        <= {CW{1'b0}};
            count_q       <= {CW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            tag_wr_q      <= {PW{1'b0}};
            tag_rd_q      <= {PW{1'b0}};
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                tag_pc_q[i]     <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_fault_q[i] <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            if (grant_s) begin
                tag_pc_q[tag_wr_q] <= pc_q;
            end
            if (push_s) begin
                fifo_instr_q[push_idx_s] <= push_instr_s;
                fifo_pc_q[push_idx_s]    <= push_pc_s;
                fifo_fault_q[push_idx_s] <= push_fault_s;
            end
        end
    end

    // Outputs come straight from registers, except the request strobe which
    // must drop in the redirect cycle itself.
    always_comb begin
        o_imem_req  = req_s;
        o_imem_addr = pc_q;
        o_if_valid  = (count_q != {CW{1'b0}});
        o_if_instr  = fifo_instr_q[rd_ptr_q];
        o_if_pc     = fifo_pc_q[rd_ptr_q];
        o_if_fault  = fifo_fault_q[rd_ptr_q];
    end

`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: entries taken by decode, and cycles decode starved.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_stall_q   <= 32'h0000_0000;
        end else begin
            if (pop_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (i_id_ready && (count_q == {CW{1'b0}}) && (state_q == ST_RUN) &&
                (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed testbench for rv32i_fetch_unit (RESET_PC = 0x100, FIFO_DEPTH = 2).
// A small in-order memory model answers granted requests one cycle later,
// optionally holding responses back or flagging a bus error at one address.
module tb_rv32i_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        o_if_fault;
    logic        i_id_ready;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] o_perf_fetched;
    logic [31:0] o_perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int req_seen = 0;

    logic [31:0] pend[$];
    bit          mem_hold = 1'b0;
    bit          err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;

    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic        got_fault[$];
    int          got_cyc[$];

    always #5 clk = ~clk;

    rv32i_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_gnt      (i_imem_gnt),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .i_imem_err      (i_imem_err),
        .o_if_valid      (o_if_valid),
        .o_if_instr      (o_if_instr),
        .o_if_pc         (o_if_pc),
        .o_if_fault      (o_if_fault),
        .i_id_ready      (i_id_ready),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc)
`ifdef RV_FETCH_PERF_EN
        ,
        .o_perf_fetched  (o_perf_fetched),
        .o_perf_stall    (o_perf_stall)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: note the grant, cross the edge, then drive the memory response.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        logic [31:0] ra;
        #1;
        g  = o_imem_req && i_imem_gnt;
        ga = o_imem_addr;
        @(posedge clk);
        #1;
        cyc_n++;
        if (g) pend.push_back(ga);
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_imem_err    = 1'b0;
        if (!mem_hold && pend.size() > 0) begin
            ra            = pend.pop_front();
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = instr_of(ra);
            i_imem_err    = err_en && (ra == err_addr);
        end
        #1;
    endtask

    // Run n cycles, logging every entry decode accepts and every request.
    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            if (o_if_valid && i_id_ready) begin
                got_pc.push_back(o_if_pc);
                got_instr.push_back(o_if_instr);
                got_fault.push_back(o_if_fault);
                got_cyc.push_back(cyc_n);
            end
            if (o_imem_req) req_seen++;
            tick();
        end
    endtask

    task automatic clear_log();
        got_pc.delete();
        got_instr.delete();
        got_fault.delete();
        got_cyc.delete();
        req_seen = 0;
    endtask

    task automatic do_reset();
        i_rst            = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;
        mem_hold         = 1'b0;
        err_en           = 1'b0;
        pend.delete();
        tick();
        tick();
        clear_log();
        i_rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b1;
        i_rst      = 1'b0;
        tick();
        tick();
        checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", o_imem_req); end
        checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_if_valid); end
        checks++; if (o_if_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", o_if_fault); end
        checks++; if (o_if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 00000000", o_if_instr); end
        checks++; if (o_if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", o_if_pc); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", o_imem_req); end
        checks++; if (o_imem_addr !== RPC) begin failures++; $display("FAIL first_addr: got %h expected %h", o_imem_addr, RPC); end
    endtask

    task automatic test_throughput();
        int base;
        clear_log();
        base = cyc_n;
        collect(12);
        checks++;
        if (got_pc.size() < 3) begin
            failures++; $display("FAIL tput_count: got %0d expected >=3", got_pc.size());
        end else begin
            checks++; if (got_pc[0] !== 32'h100) begin failures++; $display("FAIL tput_pc0: got %h expected 00000100", got_pc[0]); end
            checks++; if (got_pc[1] !== 32'h104) begin failures++; $display("FAIL tput_pc1: got %h expected 00000104", got_pc[1]); end
            checks++; if (got_pc[2] !== 32'h108) begin failures++; $display("FAIL tput_pc2: got %h expected 00000108", got_pc[2]); end
            checks++; if (got_instr[1] !== instr_of(32'h104)) begin failures++; $display("FAIL tput_instr1: got %h expected %h", got_instr[1], instr_of(32'h104)); end
            checks++; if (got_fault[0] !== 1'b0) begin failures++; $display("FAIL tput_fault0: got %b expected 0", got_fault[0]); end
            checks++; if (got_cyc[0] - base + 1 != 3) begin failures++; $display("FAIL tput_first_cycle: got %0d expected 3", got_cyc[0] - base + 1); end
            checks++; if (got_cyc[1] - got_cyc[0] != 1) begin failures++; $display("FAIL tput_consecutive: got gap %0d expected 1", got_cyc[1] - got_cyc[0]); end
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        int moved  = 0;
        do_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (o_imem_req && i_imem_gnt) grants++;
            if (k >= 3 && o_if_pc !== 32'h100) moved++;
            tick();
        end
        checks++; if (grants != 2) begin failures++; $display("FAIL bp_grants: got %0d expected 2", grants); end
        checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b expected 0", o_imem_req); end
        checks++; if (o_if_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", o_if_valid); end
        checks++; if (moved != 0 || o_if_pc !== 32'h100) begin failures++; $display("FAIL bp_hold_pc: got %h (changes %0d) expected 00000100", o_if_pc, moved); end
        i_id_ready = 1'b1;
        collect(15);
        checks++;
        if (got_pc.size() < 4) begin
            failures++; $display("FAIL bp_count: got %0d expected >=4", got_pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_pc[k] !== RPC + 32'(4 * k)) begin
                    failures++; $display("FAIL bp_order%0d: got %h expected %h", k, got_pc[k], RPC + 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b0;
        mem_hold   = 1'b1;
        tick();
        tick();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h2000;
        #1;
        checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL rd_req_in_redirect: got %b expected 0", o_imem_req); end
        tick();
        i_redirect_valid = 1'b0;
        mem_hold         = 1'b0;
        i_id_ready       = 1'b1;
        checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL rd_flushed: got %b expected 0", o_if_valid); end
        collect(15);
        checks++;
        if (got_pc.size() < 2) begin
            failures++; $display("FAIL rd_count: got %0d expected >=2", got_pc.size());
        end else begin
            checks++; if (got_pc[0] !== 32'h2000) begin failures++; $display("FAIL rd_pc0: got %h expected 00002000", got_pc[0]); end
            checks++; if (got_instr[0] !== instr_of(32'h2000)) begin failures++; $display("FAIL rd_instr0: got %h expected %h", got_instr[0], instr_of(32'h2000)); end
            checks++; if (got_pc[1] !== 32'h2004) begin failures++; $display("FAIL rd_pc1: got %h expected 00002004", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_with_rvalid();
        do_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b0;
        mem_hold   = 1'b1;
        tick();
        tick();
        mem_hold = 1'b0;
        tick();
        checks++; if (i_imem_rvalid !== 1'b1) begin failures++; $display("FAIL rv_setup: got %b expected 1", i_imem_rvalid); end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h3000;
        tick();
        i_redirect_valid = 1'b0;
        i_id_ready       = 1'b1;
        collect(12);
        checks++;
        if (got_pc.size() < 2) begin
            failures++; $display("FAIL rv_count: got %0d expected >=2", got_pc.size());
        end else begin
            checks++; if (got_pc[0] !== 32'h3000) begin failures++; $display("FAIL rv_pc0: got %h expected 00003000", got_pc[0]); end
            checks++; if (got_instr[0] !== instr_of(32'h3000)) begin failures++; $display("FAIL rv_instr0: got %h expected %h", got_instr[0], instr_of(32'h3000)); end
            checks++; if (got_pc[1] !== 32'h3004) begin failures++; $display("FAIL rv_pc1: got %h expected 00003004", got_pc[1]); end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b0;
        tick();
        tick();
        tick();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h2002;
        tick();
        i_redirect_valid = 1'b0;
        checks++; if (o_if_valid !== 1'b1) begin failures++; $display("FAIL mis_valid: got %b expected 1", o_if_valid); end
        checks++; if (o_if_pc !== 32'h2002) begin failures++; $display("FAIL mis_pc: got %h expected 00002002", o_if_pc); end
        checks++; if (o_if_fault !== 1'b1) begin failures++; $display("FAIL mis_fault: got %b expected 1", o_if_fault); end
        checks++; if (o_if_instr !== NOP) begin failures++; $display("FAIL mis_instr: got %h expected %h", o_if_instr, NOP); end
        collect(5);
        i_id_ready = 1'b1;
        collect(6);
        checks++; if (got_pc.size() != 1) begin failures++; $display("FAIL mis_entries: got %0d expected 1", got_pc.size()); end
        checks++; if (req_seen != 0) begin failures++; $display("FAIL mis_no_req: got %0d expected 0", req_seen); end
        clear_log();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h3000;
        tick();
        i_redirect_valid = 1'b0;
        collect(8);
        checks++;
        if (got_pc.size() < 1) begin
            failures++; $display("FAIL mis_resume_count: got %0d expected >=1", got_pc.size());
        end else begin
            checks++; if (got_pc[0] !== 32'h3000 || got_fault[0] !== 1'b0) begin failures++; $display("FAIL mis_resume: got %h/%b expected 00003000/0", got_pc[0], got_fault[0]); end
        end
    endtask

    task automatic test_bus_error();
        do_reset();
        i_imem_gnt = 1'b1;
        i_id_ready = 1'b1;
        err_en     = 1'b1;
        err_addr   = 32'h104;
        collect(12);
        checks++;
        if (got_pc.size() != 2) begin
            failures++; $display("FAIL err_count: got %0d expected 2", got_pc.size());
        end else begin
            checks++; if (got_pc[0] !== 32'h100 || got_fault[0] !== 1'b0) begin failures++; $display("FAIL err_first: got %h/%b expected 00000100/0", got_pc[0], got_fault[0]); end
            checks++; if (got_pc[1] !== 32'h104 || got_fault[1] !== 1'b1) begin failures++; $display("FAIL err_entry: got %h/%b expected 00000104/1", got_pc[1], got_fault[1]); end
            checks++; if (got_instr[1] !== NOP) begin failures++; $display("FAIL err_instr: got %h expected %h", got_instr[1], NOP); end
        end
        checks++; if (req_seen != 2) begin failures++; $display("FAIL err_halt_reqs: got %0d expected 2", req_seen); end
        err_en = 1'b0;
        i_rst  = 1'b0;
        tick();
        i_rst = 1'b1;
        #1;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RPC) begin failures++; $display("FAIL err_restart: got %b/%h expected 1/%h", o_imem_req, o_imem_addr, RPC); end
        checks++; if (o_if_valid !== 1'b0) begin failures++; $display("FAIL err_restart_valid: got %b expected 0", o_if_valid); end
        clear_log();
        collect(6);
        checks++;
        if (got_pc.size() < 1 || got_pc[0] !== RPC || got_fault[0] !== 1'b0) begin
            failures++; $display("FAIL err_restart_fetch: got %0d entries expected first 00000100 clean", got_pc.size());
        end
    endtask

    initial begin
        i_rst            = 1'b0;
        i_imem_gnt       = 1'b0;
        i_imem_rvalid    = 1'b0;
        i_imem_rdata     = 32'h0;
        i_imem_err       = 1'b0;
        i_id_ready       = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;
        test_reset();
        test_throughput();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rvalid();
        test_misaligned();
        test_bus_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
